// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS core: opcode/funct
// encodings, FSM state enum, ALU-op enum and a decode helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: is_legal = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                           (fn == FN_OR)  || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  // Only R-type picks its operation from funct; everything else adds.
  function automatic alu_op_e alu_sel(input logic [5:0] op, input logic [5:0] fn);
    alu_sel = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  alu_sel = ALU_SUB;
        FN_AND:  alu_sel = ALU_AND;
        FN_OR:   alu_sel = ALU_OR;
        FN_SLT:  alu_sel = ALU_SLT;
        default: alu_sel = ALU_ADD;
      endcase
    end
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: async reads (third debug read port under
// MIPS_DBG_PORT_EN), one sync write port, sync clear while reset_n is low.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ra1,
  output logic [31:0] rd1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2,
`ifdef MIPS_DBG_PORT_EN
  input  logic [4:0]  ra3,
  output logic [31:0] rd3,
`endif
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0][31:0] regs;

  always_ff @(posedge clk) begin
    if (!reset_n) regs <= '0;
    else if (we && (wa != 5'd0)) regs[wa] <= wd;
  end

  // R0 is hardwired to zero on every read port.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
`ifdef MIPS_DBG_PORT_EN
  assign rd3 = (ra3 == 5'd0) ? 32'd0 : regs[ra3];
`endif

endmodule

// File: rtl/mips_multi_core.sv
// Multi-cycle MIPS subset core with handshaked instruction/data memories.
// Define MIPS_DBG_PORT_EN to add the dbg_sel/dbg_data register readout port.
module mips_multi_core
  import mips_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int DA_W     = 10,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DA_W-1:0] dmem_addr,
  output logic [31:0]     dmem_wdata,
  input  logic [31:0]     dmem_rdata,
  input  logic            dmem_ready,
`ifdef MIPS_DBG_PORT_EN
  input  logic [4:0]      dbg_sel,
  output logic [31:0]     dbg_data,
`endif
  output logic            halted,
  output logic [PC_W-1:0] pc_out
);
  localparam logic [PC_W-1:0] PC0 = PC_W'(RESET_PC);

  state_e          state, state_nx;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir, a, b, imm, alu_out, mdr;
  logic [31:0]     rs_data, rt_data, alu_b, alu_res, rf_wdata;
  logic [4:0]      rf_waddr;
  logic            rf_we, is_br, br_take;
  logic [5:0]      op, fn;

  assign op      = ir[31:26];
  assign fn      = ir[5:0];
  assign is_br   = (op == OP_BEQ) || (op == OP_BNE);
  assign br_take = (op == OP_BEQ) ? (a == b) : (a != b);

  mips_regfile u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .ra1     (ir[25:21]),
    .rd1     (rs_data),
    .ra2     (ir[20:16]),
    .rd2     (rt_data),
`ifdef MIPS_DBG_PORT_EN
    .ra3     (dbg_sel),
    .rd3     (dbg_data),
`endif
    .we      (rf_we),
    .wa      (rf_waddr),
    .wd      (rf_wdata)
  );

  always_comb begin
    alu_b = (op == OP_RTYPE) ? b : imm;
    case (alu_sel(op, fn))
      ALU_SUB: alu_res = a - alu_b;
      ALU_AND: alu_res = a & alu_b;
      ALU_OR:  alu_res = a | alu_b;
      ALU_SLT: alu_res = {31'd0, ($signed(a) < $signed(alu_b))};
      default: alu_res = a + alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_RESET;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = (op == OP_RTYPE) ? ir[15:11] : ir[20:16];
    rf_wdata = (op == OP_LW) ? mdr : alu_out;
    case (state)
      S_RESET:  state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (!is_legal(op, fn)) state_nx = S_HALT;
        else if (op == OP_J)   state_nx = S_FETCH;
        else                   state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (is_br)                            state_nx = S_FETCH;
        else if (op == OP_LW || op == OP_SW)  state_nx = S_MEM;
        else                                  state_nx = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) state_nx = (op == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        rf_we    = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RESET;
    endcase
  end

  // PC already points past the fetched word, so branches add imm to PC+1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc      <= PC0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        S_RESET: pc <= PC0;
        S_FETCH: if (imem_ready) begin
          ir <= imem_rdata;
          pc <= pc + PC_W'(1);
        end
        S_DECODE: begin
          a   <= rs_data;
          b   <= rt_data;
          imm <= {{16{ir[15]}}, ir[15:0]};
          if (op == OP_J) pc <= ir[PC_W-1:0];
        end
        S_EXEC: begin
          if (is_br) begin
            if (br_take) pc <= pc + imm[PC_W-1:0];
          end else begin
            alu_out <= alu_res;
          end
        end
        S_MEM: if (dmem_ready && op == OP_LW) mdr <= dmem_rdata;
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign dmem_we    = dmem_req && (op == OP_SW);
  assign dmem_addr  = alu_out[DA_W-1:0];
  assign dmem_wdata = b;
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_mips_multi_core.sv
// Bench for mips_multi_core: memory responders with optional wait states and an
// instruction-level reference model that predicts fetch trace, latencies and stores.
module tb_mips_multi_core;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req, imem_ready = 1'b0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata = '0;
  logic        halted;
  logic [9:0]  pc_out;

  mips_multi_core dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .halted(halted), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ILL = 32'hFC00_0000;

  int vectors = 0, miscompares = 0;
  bit [31:0] imem [1024];
  bit [31:0] dmem [1024];

  // responder state and observation logs
  int  iwait = 0, dwait = 0;
  bit  rnd_wait = 0;
  int  cyc = 0, icnt = 0, dcnt = 0, iw = 0, dw = 0, unstable = 0;
  logic [9:0]  a0;
  logic        we0;
  logic [31:0] wd0;
  int f_addr[$];
  int f_cyc[$];
  typedef struct { logic [9:0] addr; logic we; logic [31:0] wd; int cnt; } dacc_t;
  dacc_t dacc[$];

  // expected results from the reference model
  int e_fetch[$];
  int e_lat[$];
  logic [31:0] e_sa[$];
  logic [31:0] e_sd[$];

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_ins(input int t);
    return {6'h02, 26'(t)};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (imem_req === 1'b1) begin
        icnt++;
        if (icnt == 1) begin
          iw = rnd_wait ? int'($urandom_range(0, 3)) : iwait;
          f_addr.push_back(int'(imem_addr));
          f_cyc.push_back(cyc);
        end
        imem_ready = (icnt > iw);
        imem_rdata = imem_ready ? imem[imem_addr] : $urandom;
      end else begin
        icnt = 0; imem_ready = 1'b0; imem_rdata = $urandom;
      end
      if (dmem_req !== 1'b1 && dmem_we === 1'b1) unstable++;
      if (dmem_req === 1'b1) begin
        dcnt++;
        if (dcnt == 1) begin
          dw = rnd_wait ? int'($urandom_range(0, 3)) : dwait;
          a0 = dmem_addr; we0 = dmem_we; wd0 = dmem_wdata;
        end else if (a0 !== dmem_addr || we0 !== dmem_we || wd0 !== dmem_wdata) unstable++;
        dmem_ready = (dcnt > dw);
        dmem_rdata = dmem_ready ? dmem[dmem_addr] : $urandom;
        if (dmem_ready) begin
          dacc.push_back('{addr: a0, we: we0, wd: wd0, cnt: dcnt});
          if (we0) dmem[a0] = wd0;
        end
      end else begin
        dcnt = 0; dmem_ready = 1'b0; dmem_rdata = $urandom;
      end
    end
  end

  // Executes imem from address 0 one instruction at a time until an illegal word.
  task automatic model_run();
    logic [31:0] r [32];
    logic [31:0] m [1024];
    logic [31:0] ins, se, va, vb, val, ea;
    int pc, steps, dst, lat;
    bit done, wr;
    for (int i = 0; i < 32; i++) r[i] = 0;
    for (int i = 0; i < 1024; i++) m[i] = dmem[i];
    e_fetch.delete(); e_lat.delete(); e_sa.delete(); e_sd.delete();
    pc = 0; steps = 0; done = 0;
    while (!done && steps < 500) begin
      ins = imem[pc];
      e_fetch.push_back(pc);
      steps++;
      pc = (pc + 1) % 1024;
      se = {{16{ins[15]}}, ins[15:0]};
      va = r[ins[25:21]];
      vb = r[ins[20:16]];
      wr = 0; dst = int'(ins[20:16]); val = 0; lat = 4;
      case (ins[31:26])
        6'h00: begin
          wr = 1; dst = int'(ins[15:11]);
          case (ins[5:0])
            6'h20: val = va + vb;
            6'h22: val = va - vb;
            6'h24: val = va & vb;
            6'h25: val = va | vb;
            6'h2A: val = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            default: done = 1;
          endcase
        end
        6'h08: begin wr = 1; val = va + se; end
        6'h04: begin lat = 3; if (va == vb) pc = int'((pc + se) & 32'h3FF); end
        6'h05: begin lat = 3; if (va != vb) pc = int'((pc + se) & 32'h3FF); end
        6'h23: begin lat = 5; wr = 1; ea = (va + se) & 32'h3FF; val = m[ea]; end
        6'h2B: begin ea = (va + se) & 32'h3FF; m[ea] = vb; e_sa.push_back(ea); e_sd.push_back(vb); end
        6'h02: begin lat = 2; pc = int'(ins[9:0]); end
        default: done = 1;
      endcase
      if (!done) begin
        if (wr && dst != 0) r[dst] = val;
        e_lat.push_back(lat);
      end
    end
  endtask

  task automatic clear_logs();
    f_addr.delete(); f_cyc.delete(); dacc.delete(); unstable = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    clear_logs();
    reset_n = 1'b1;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 3000 && halted !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic check_run(input string nm, input bit chk_lat);
    int k;
    logic [31:0] sa[$];
    logic [31:0] sd[$];
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL %s halted got %b want 1", nm, halted); end
    vectors++;
    if (f_addr.size() != e_fetch.size()) begin
      miscompares++; $display("FAIL %s fetch_count got %0d want %0d", nm, f_addr.size(), e_fetch.size());
    end
    for (k = 0; k < e_fetch.size() && k < f_addr.size(); k++) begin
      vectors++;
      if (f_addr[k] != e_fetch[k]) begin
        miscompares++; $display("FAIL %s fetch[%0d] got %h want %h", nm, k, f_addr[k], e_fetch[k]);
      end
    end
    if (chk_lat) begin
      for (k = 0; k < e_lat.size() && k + 1 < f_cyc.size(); k++) begin
        vectors++;
        if (f_cyc[k+1] - f_cyc[k] != e_lat[k]) begin
          miscompares++;
          $display("FAIL %s latency[%0d] got %0d want %0d", nm, k, f_cyc[k+1] - f_cyc[k], e_lat[k]);
        end
      end
    end
    foreach (dacc[i]) if (dacc[i].we) begin sa.push_back(32'(dacc[i].addr)); sd.push_back(dacc[i].wd); end
    vectors++;
    if (sa.size() != e_sa.size()) begin
      miscompares++; $display("FAIL %s store_count got %0d want %0d", nm, sa.size(), e_sa.size());
    end
    for (k = 0; k < e_sa.size() && k < sa.size(); k++) begin
      vectors++;
      if (sa[k] !== e_sa[k] || sd[k] !== e_sd[k]) begin
        miscompares++;
        $display("FAIL %s store[%0d] got %h@%h want %h@%h", nm, k, sd[k], sa[k], e_sd[k], e_sa[k]);
      end
    end
    vectors++;
    if (unstable != 0) begin miscompares++; $display("FAIL %s dmem_protocol got %0d errors want 0", nm, unstable); end
  endtask

  task automatic run_prog(input string nm, input bit chk_lat);
    model_run();
    do_reset();
    wait_halt();
    check_run(nm, chk_lat);
  endtask

  task automatic load_ill();
    for (int i = 0; i < 1024; i++) imem[i] = ILL;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({imem_req, dmem_req, dmem_we, halted} !== 4'b0000 || pc_out !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got req/dreq/we/halt=%b%b%b%b pc=%h want 0000 pc=000",
               imem_req, dmem_req, dmem_we, halted, pc_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
      miscompares++; $display("FAIL first_fetch got req=%b addr=%h want 1 000", imem_req, imem_addr);
    end
  endtask

  task automatic test_alu();
    int p;
    load_ill(); iwait = 0; dwait = 0; rnd_wait = 0;
    imem[0] = i_ins(6'h08, 0, 1, 5);
    imem[1] = i_ins(6'h08, 0, 2, -3);
    imem[2] = r_ins(6'h20, 1, 2, 3);
    imem[3] = r_ins(6'h2A, 2, 1, 4);
    imem[4] = i_ins(6'h08, 0, 0, 7);
    imem[5] = i_ins(6'h08, 0, 6, 16'h4000);
    for (p = 6; p < 23; p++) imem[p] = r_ins(6'h20, 6, 6, 6);
    imem[23] = i_ins(6'h08, 6, 7, -1);
    imem[24] = i_ins(6'h08, 0, 9, 1);
    imem[25] = r_ins(6'h20, 7, 9, 10);
    imem[26] = i_ins(6'h2B, 0, 3, 0);
    imem[27] = i_ins(6'h2B, 0, 4, 1);
    imem[28] = i_ins(6'h2B, 0, 0, 2);
    imem[29] = i_ins(6'h2B, 0, 10, 3);
    run_prog("alu", 1'b1);
    vectors++;
    if (dacc.size() != 4 || dacc[0].wd !== 32'd2 || dacc[1].wd !== 32'd1 ||
        dacc[2].wd !== 32'd0 || dacc[3].wd !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL alu_results got %0d stores want R3=2 R4=1 R0=0 R10=80000000", dacc.size());
    end
  endtask

  task automatic test_mem();
    load_ill(); iwait = 0; dwait = 3; rnd_wait = 0;
    imem[0] = i_ins(6'h08, 0, 1, 5);
    imem[1] = i_ins(6'h2B, 0, 1, 4);
    imem[2] = i_ins(6'h23, 0, 5, 4);
    imem[3] = i_ins(6'h2B, 0, 5, 8);
    run_prog("mem", 1'b0);
    vectors++;
    if (dacc.size() != 3) begin
      miscompares++; $display("FAIL mem_access_count got %0d want 3", dacc.size());
    end else begin
      vectors++;
      if (dacc[0].cnt != 4 || dacc[0].addr !== 10'd4 || dacc[0].wd !== 32'd5 || dacc[0].we !== 1'b1) begin
        miscompares++;
        $display("FAIL mem_sw got cnt=%0d addr=%h wd=%h we=%b want 4 004 5 1",
                 dacc[0].cnt, dacc[0].addr, dacc[0].wd, dacc[0].we);
      end
      vectors++;
      if (dacc[1].cnt != 4 || dacc[1].addr !== 10'd4 || dacc[1].we !== 1'b0) begin
        miscompares++;
        $display("FAIL mem_lw got cnt=%0d addr=%h we=%b want 4 004 0", dacc[1].cnt, dacc[1].addr, dacc[1].we);
      end
      vectors++;
      if (dacc[2].wd !== 32'd5) begin
        miscompares++; $display("FAIL mem_r5 got %h want 5", dacc[2].wd);
      end
    end
  endtask

  task automatic test_branch();
    load_ill(); iwait = 0; dwait = 0; rnd_wait = 0;
    imem[0] = i_ins(6'h08, 3, 3, 1);
    imem[1] = i_ins(6'h08, 0, 5, 1);
    imem[2] = i_ins(6'h05, 0, 0, 5);
    imem[3] = i_ins(6'h04, 3, 5, -4);
    imem[4] = i_ins(6'h2B, 0, 3, 0);
    run_prog("branch", 1'b1);
    vectors++;
    if (f_addr.size() < 5 || f_addr[3] != 3 || f_addr[4] != 0) begin
      miscompares++; $display("FAIL branch_targets got %0d fetches want ...,3,0,...", f_addr.size());
    end
    load_ill();
    imem[0] = i_ins(6'h08, 7, 7, 1);
    imem[1] = i_ins(6'h08, 0, 8, 2);
    imem[2] = i_ins(6'h04, 7, 8, 5);
    imem[3] = j_ins(10'h3FF);
    imem[10'h3FF] = r_ins(6'h20, 7, 7, 9);
    imem[8] = i_ins(6'h2B, 0, 9, 0);
    run_prog("jump", 1'b1);
    vectors++;
    if (f_addr.size() < 6 || f_addr[4] != 10'h3FF || f_addr[5] != 0) begin
      miscompares++; $display("FAIL jump_wrap got %0d fetches want ...,3ff,000,...", f_addr.size());
    end
  endtask

  task automatic test_halt();
    int busy = 0;
    load_ill(); iwait = 0; dwait = 0; rnd_wait = 0;
    imem[0] = i_ins(6'h08, 0, 1, 1);
    imem[1] = i_ins(6'h2B, 0, 1, 0);
    imem[3] = i_ins(6'h08, 0, 2, 2);
    run_prog("halt", 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1) busy++;
    end
    vectors++;
    if (busy != 0) begin miscompares++; $display("FAIL halt_absorb got %0d bad cycles want 0", busy); end
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_clear got %b want 0", halted); end
    clear_logs();
    reset_n = 1'b1;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
      miscompares++; $display("FAIL halt_restart got req=%b addr=%h want 1 000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    load_ill(); iwait = 0; dwait = 10; rnd_wait = 0;
    imem[0] = i_ins(6'h08, 0, 1, 5);
    imem[1] = i_ins(6'h08, 0, 2, 9);
    imem[2] = i_ins(6'h23, 0, 3, 0);
    do_reset();
    for (int i = 0; i < 100 && dmem_req !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL rmid_lw_start got %b want 1", dmem_req); end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dmem_req, dmem_we, imem_req, halted} !== 4'b0000 || pc_out !== 10'd0) begin
      miscompares++;
      $display("FAIL rmid_outputs got dreq/we/req/halt=%b%b%b%b pc=%h want 0000 pc=000",
               dmem_req, dmem_we, imem_req, halted, pc_out);
    end
    load_ill(); dwait = 0;
    for (int i = 1; i < 32; i++) imem[i-1] = i_ins(6'h2B, 0, i, 64 + i);
    model_run();
    clear_logs();
    reset_n = 1'b1;
    wait_halt();
    check_run("rmid_regs", 1'b1);
  endtask

  task automatic test_random();
    int n, sel, rs, rt, rd;
    for (int t = 0; t < 16; t++) begin
      load_ill();
      for (int i = 0; i < 48; i++) dmem[i] = $urandom;
      rnd_wait = t[0]; iwait = 0; dwait = 0;
      n = 24;
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(0, 9);
        rs = $urandom_range(0, 7); rt = $urandom_range(1, 7); rd = $urandom_range(0, 7);
        case (sel)
          0, 1: imem[k] = i_ins(6'h08, rs, rt, int'($urandom_range(0, 65535)));
          2: imem[k] = r_ins(6'h20, rs, rt, rd);
          3: imem[k] = r_ins(6'h22, rs, rt, rd);
          4: imem[k] = r_ins(6'h24, rs, rt, rd);
          5: imem[k] = r_ins(6'h25, rs, rt, rd);
          6: imem[k] = r_ins(6'h2A, rs, rt, rd);
          7: imem[k] = i_ins(6'h23, 0, rt, int'($urandom_range(0, 47)));
          8: imem[k] = i_ins(6'h2B, 0, rt, int'($urandom_range(0, 47)));
          default: imem[k] = i_ins($urandom_range(0, 1) ? 6'h04 : 6'h05, rs, rt, int'($urandom_range(0, 3)));
        endcase
      end
      for (int i = 1; i < 8; i++) imem[n + i - 1] = i_ins(6'h2B, 0, i, 100 + i);
      run_prog("random", !rnd_wait);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_halt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
